// File: rtl/sum_seq_ctrl_pkg.sv
// sum_seq_ctrl_pkg: shared slice width and controller state encoding
package sum_seq_ctrl_pkg;
    localparam int NIB_W = 4;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/sum_seq_ctrl_if.sv
// sum_seq_ctrl_if: operand/result bus with start/busy/done handshake
interface sum_seq_ctrl_if
    import sum_seq_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
);
    localparam int W = NIB_W * NIBBLES;
    logic         init;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] S;
    logic         co;
    logic         busy;
    logic         done;
    modport master (output init, A, B, input S, co, busy, done);
    modport slave (input init, A, B, output S, co, busy, done);
endinterface

// File: rtl/sum_seq_ctrl_sum4b_cin.sv
// sum4b_cin: combinational 4-bit adder slice with carry-in
module sum4b_cin
    import sum_seq_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] xi,
    input  logic [NIB_W-1:0] yi,
    input  logic             ci,
    output logic [NIB_W-1:0] zi,
    output logic             co
);
    assign {co, zi} = {1'b0, xi} + {1'b0, yi} + {{NIB_W{1'b0}}, ci};
endmodule

// File: rtl/sum_seq_ctrl.sv
// sum_seq_ctrl: nibble-serial wide adder reusing one 4-bit slice, LS nibble first
module sum_seq_ctrl
    import sum_seq_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input logic clk,
    input logic rst,
    sum_seq_ctrl_if.slave bus
);
    localparam int W  = NIB_W * NIBBLES;
    localparam int IW = 3;
    state_t           state;
    state_t           nxt;
    logic [W-1:0]     ra;
    logic [W-1:0]     rb;
    logic [W-1:0]     acc;
    logic [W-1:0]     acc_nxt;
    logic [NIB_W-1:0] zs;
    logic             zc;
    logic             cr;
    logic             last;
    logic [IW-1:0]    idx;

    sum4b_cin u_slice (
        .xi(ra[NIB_W-1:0]),
        .yi(rb[NIB_W-1:0]),
        .ci(cr),
        .zi(zs),
        .co(zc)
    );

    assign last     = idx == IW'(NIBBLES - 1);
    assign acc_nxt  = W'({zs, acc} >> NIB_W);
    assign bus.busy = state != ST_IDLE;
    assign bus.done = state == ST_DONE;

    // state register; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt;
    end

    // next state: accept init only when idle, leave ADD after the top nibble
    always_comb begin
        nxt = ST_IDLE;
        if (state == ST_IDLE)     nxt = bus.init ? ST_ADD : ST_IDLE;
        else if (state == ST_ADD) nxt = last ? ST_DONE : ST_ADD;
    end

    // datapath: latch operands, then one slice per cycle with chained carry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra     <= '0;
            rb     <= '0;
            acc    <= '0;
            cr     <= 1'b0;
            idx    <= '0;
            bus.S  <= '0;
            bus.co <= 1'b0;
        end else if (state == ST_IDLE && bus.init) begin
            ra  <= bus.A;
            rb  <= bus.B;
            cr  <= 1'b0;
            idx <= '0;
        end else if (state == ST_ADD) begin
            ra  <= ra >> NIB_W;
            rb  <= rb >> NIB_W;
            acc <= acc_nxt;
            cr  <= zc;
            idx <= idx + 1'b1;
            if (last) begin
                bus.S  <= acc_nxt;
                bus.co <= zc;
            end
        end
    end
endmodule

// File: tb/tb_sum_seq_ctrl.sv
// tb_sum_seq_ctrl: scoreboard bench for the 4-nibble and 1-nibble adder controllers
module tb_sum_seq_ctrl;
    logic clk;
    logic rst;
    int total;
    int bad;
    int n_done4;
    logic [16:0] q4[$];
    logic [4:0] q1[$];
    time done_t[$];
    logic [16:0] e4;
    logic [4:0] e1;

    sum_seq_ctrl_if #(.NIBBLES(4)) bus4 ();
    sum_seq_ctrl_if #(.NIBBLES(1)) bus1 ();

    sum_seq_ctrl #(.NIBBLES(4)) u4 (.clk(clk), .rst(rst), .bus(bus4));
    sum_seq_ctrl #(.NIBBLES(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    // monitor for the 4-nibble unit: every done pops one expected {co,S}
    always @(negedge clk) begin
        if (bus4.done) begin
            n_done4++;
            done_t.push_back($time);
            total++;
            if (q4.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done4 got=%h want=none", {bus4.co, bus4.S});
            end else begin
                e4 = q4.pop_front();
                if ({bus4.co, bus4.S} !== e4) begin
                    bad++;
                    $display("FAIL result4 got=%h want=%h", {bus4.co, bus4.S}, e4);
                end
            end
        end
    end

    // monitor for the 1-nibble unit
    always @(negedge clk) begin
        if (bus1.done) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done1 got=%h want=none", {bus1.co, bus1.S});
            end else begin
                e1 = q1.pop_front();
                if ({bus1.co, bus1.S} !== e1) begin
                    bad++;
                    $display("FAIL result1 got=%h want=%h", {bus1.co, bus1.S}, e1);
                end
            end
        end
    end

    task automatic run_op(input bit one, input logic [15:0] a, input logic [15:0] b, input bit jit);
        int n;
        int k;
        n = one ? 1 : 4;
        @(posedge clk);
        #1;
        if (one) begin
            bus1.init = 1'b1;
            bus1.A = a[3:0];
            bus1.B = b[3:0];
            q1.push_back({1'b0, a[3:0]} + {1'b0, b[3:0]});
        end else begin
            bus4.init = 1'b1;
            bus4.A = a;
            bus4.B = b;
            q4.push_back({1'b0, a} + {1'b0, b});
        end
        @(posedge clk);
        #1;
        bus1.init = 1'b0;
        bus4.init = 1'b0;
        k = 0;
        while (k <= n + 2) begin
            @(negedge clk);
            if (one ? bus1.done : bus4.done) break;
            if (jit) begin
                bus4.A = 16'($urandom);
                bus4.B = 16'($urandom);
                bus4.init = 1'($urandom_range(0, 1));
            end
            k++;
        end
        bus4.init = 1'b0;
        chk(one ? "latency1" : "latency4", k, n);
        chk("busy_at_done", {31'd0, one ? bus1.busy : bus4.busy}, 1);
        @(negedge clk);
        chk("idle_after_done", {30'd0, one ? {bus1.busy, bus1.done} : {bus4.busy, bus4.done}}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int seen;
        total = 0;
        bad = 0;
        n_done4 = 0;
        rst = 1'b1;
        bus4.init = 1'b0; bus4.A = '0; bus4.B = '0;
        bus1.init = 1'b0; bus1.A = '0; bus1.B = '0;
        #1;
        chk("reset_state", {bus4.co, bus4.busy, bus4.done, bus4.S}, 0);
        #11 rst = 1'b0;

        run_op(0, 16'h1234, 16'h4321, 0);
        run_op(0, 16'h0FFF, 16'h0001, 0);
        run_op(0, 16'hFFFF, 16'h0001, 0);
        run_op(0, 16'hFFFF, 16'hFFFF, 0);
        chk("hold_after_done", {bus4.co, bus4.S}, 17'h1FFFE);

        // init pulsed while busy must be ignored
        @(posedge clk); #1;
        bus4.init = 1'b1; bus4.A = 16'h0001; bus4.B = 16'h0002;
        q4.push_back(17'h00003);
        @(posedge clk); #1;
        bus4.init = 1'b0;
        @(posedge clk); #1;
        bus4.init = 1'b1; bus4.A = 16'hAAAA; bus4.B = 16'h5555;
        @(posedge clk); #1;
        bus4.init = 1'b0;
        seen = n_done4;
        repeat (15) @(negedge clk);
        chk("busy_protect_dones", n_done4 - seen, 1);
        chk("busy_protect_S", {bus4.co, bus4.S}, 17'h00003);

        // init held high: back-to-back operations every NIBBLES+2 cycles
        done_t.delete();
        @(posedge clk); #1;
        bus4.init = 1'b1; bus4.A = 16'h1234; bus4.B = 16'h1111;
        q4.push_back(17'h02345);
        q4.push_back(17'h02345);
        repeat (7) @(posedge clk);
        #1 bus4.init = 1'b0;
        k = 0;
        while (done_t.size() < 2 && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("held_init_dones", done_t.size(), 2);
        if (done_t.size() >= 2) chk("throughput", 32'(done_t[1] - done_t[0]), 60);
        repeat (4) @(negedge clk);
        chk("held_init_idle", {31'd0, bus4.busy}, 0);

        // reset in the middle of an operation aborts it at once
        @(posedge clk); #1;
        bus4.init = 1'b1; bus4.A = 16'h8000; bus4.B = 16'h8000;
        @(posedge clk); #1;
        bus4.init = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_reset", {bus4.co, bus4.busy, bus4.done, bus4.S}, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = n_done4;
        repeat (6) @(negedge clk);
        chk("aborted_no_done", n_done4 - seen, 0);
        run_op(0, 16'h0010, 16'h0020, 0);

        for (int i = 0; i < 40; i++) run_op(0, 16'($urandom), 16'($urandom), 1);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_op(1, 16'(a), 16'(b), 0);

        repeat (4) @(negedge clk);
        chk("q4_drained", q4.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sum_seq_ctrl.md
Name: sum_seq_ctrl

Overview:
- Multi-cycle wide adder controller.
- Reuses one 4-bit adder slice to add two operands of 4*NIBBLES bits, one nibble per clock, least significant nibble first.
- The carry is chained through a register between nibbles.
- Sits between the lab's operand registers/switches and the display path, with a start/busy/done handshake.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- init  input  1  start request; sampled only in IDLE.
- A  input  W  operand A; latched when init is accepted.
- B  input  W  operand B; latched when init is accepted.
- S  output  W  sum, (A+B) mod 2^W; registered.
- co  output  1  carry out of the most significant nibble; registered.
- busy  output  1  high from init acceptance until the end of the DONE cycle.
- done  output  1  one-cycle pulse; marks S/co valid.

Behaviour:
- Reset (rst=1, async): state=IDLE; S=0, co=0, busy=0, done=0; internal operand shift registers, carry register and nibble counter cleared.
- Reset mid-operation aborts immediately; no partial result is ever driven on S.
- States: IDLE, ADD, DONE.
- IDLE:
  - busy=0, done=0.
  - init=1 at edge t0 latches A,B into shift registers, clears the carry register, sets idx=0, and moves to ADD (busy=1 from t0).
- ADD, one nibble per edge:
  - Slice inputs are the low nibble of each shift register plus the carry register.
  - The 4-bit slice sum shifts into the top of an internal accumulator (right shift by 4).
  - The slice carry-out loads the carry register; both operand registers shift right by 4; idx increments.
  - On the edge where idx==NIBBLES-1, the accumulator result loads S, the final carry loads co, and the state moves to DONE.
- DONE:
  - done=1, busy=1 for exactly one cycle, then IDLE.
  - S and co hold until the next accepted init has finished (they update only on ADD→DONE).
- Latency: init sampled at edge t0 → S/co updated and done=1 after edge t0+NIBBLES; IDLE after edge t0+NIBBLES+1.
- Throughput: one operation per NIBBLES+2 cycles if init is held high.
- init while busy (ADD or DONE): ignored, not queued.
- A/B changes while busy: no effect on the result.
- init level-sensitive in IDLE: holding it high restarts a new operation on the cycle after DONE.
- Carry rule: carry register starts at 0 and is never injected from outside. co = bit W of the full unsigned sum.
- NIBBLES=1 degenerates to a 1-cycle ADD; must match the plain 4-bit adder for all inputs.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_ADD, ST_DONE, 2 bits) and the slice width constant NIB_W=4.
- One sub-module: sum4b_cin, a combinational 4-bit slice with carry-in (ports xi, yi, ci, zi, co). The controller instantiates it once.
- Counter, shift registers, accumulator and FSM stay in sum_seq_ctrl.

Test Plan (NIBBLES=4 unless noted):
- Reset: assert rst async between edges with outputs nonzero → S=0x0000, co=0, busy=0, done=0 immediately, no clock needed.
- A=0x1234, B=0x4321, init pulse at t0 → done=1 only in the cycle after edge t0+4; S=0x5555, co=0; busy high t0..t0+5; IDLE at t0+5.
- Carry propagation: A=0x0FFF, B=0x0001 → S=0x1000, co=0. A=0xFFFF, B=0x0001 → S=0x0000, co=1. A=0xFFFF, B=0xFFFF → S=0xFFFE, co=1.
- Busy protection: start A=0x0001, B=0x0002; at t0+2 pulse init with A=0xAAAA, B=0x5555 → first result S=0x0003, co=0. No second done follows, and S stays 0x0003.
- Reset mid-op: start A=0x8000, B=0x8000; assert rst after edge t0+2; release; start A=0x0010, B=0x0020 → no done for the aborted op; second result S=0x0030, co=0.
- NIBBLES=1 exhaustive: all A,B in 0..15 → {co,S}=A+B, done after edge t0+1, matches the 4-bit adder reference model.
